// File: rtl/decode_scoreboard.sv
// Decode stage with a per-register outstanding-write scoreboard.
// Decodes a MIPS subset, stalls on RAW hazards or counter saturation,
// registers operands toward ID/EX and resolves beq/bne one cycle after accept.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its payload stable until the transfer;
// ready may depend combinationally on valid. in_ready is forced high while a
// taken branch is being redirected so the wrong-path instruction drains.
module decode_scoreboard #(
  parameter int XLEN     = 32,
  parameter int PC_W     = 32,
  parameter int SB_CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic [4:0]      rf_raddr1,
  output logic [4:0]      rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_op,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_dest,
  output logic            out_wen,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [XLEN-1:0] out_imm,
  output logic            br_taken,
  output logic [PC_W-1:0] br_target,
  output logic            hazard
);

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam int         CW      = SB_CNT_W + 2;

  logic [SB_CNT_W-1:0] sb_cnt  [32];
  logic [SB_CNT_W-1:0] sb_next [32];

  logic [5:0]      opcode;
  logic [4:0]      rs, rt, rd, dest;
  logic            reads_rs, reads_rt, has_dest, is_branch, uses_imm;
  logic            wen, rs_busy, rt_busy, dest_sat, accept, br_cond;
  logic [XLEN-1:0] imm_sext;
  logic [PC_W-1:0] br_off;
  logic [31:0]     inc_vec, wbdec_vec, fldec_vec;
  logic [CW-1:0]   sum, dec;

  assign opcode    = in_instr[31:26];
  assign rs        = in_instr[25:21];
  assign rt        = in_instr[20:16];
  assign rd        = in_instr[15:11];
  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;
  assign imm_sext  = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};
  assign br_off    = {{(PC_W-18){in_instr[15]}}, in_instr[15:0], 2'b00};

  // Instruction class decode: which sources are read and which register is written.
  always_comb begin
    reads_rs  = 1'b0;
    reads_rt  = 1'b0;
    has_dest  = 1'b0;
    dest      = 5'd0;
    is_branch = 1'b0;
    uses_imm  = 1'b0;
    case (opcode)
      OP_R:           begin reads_rs = 1'b1; reads_rt = 1'b1; has_dest = 1'b1; dest = rd; end
      OP_ADDI, OP_LW: begin reads_rs = 1'b1; has_dest = 1'b1; dest = rt; uses_imm = 1'b1; end
      OP_SW:          begin reads_rs = 1'b1; reads_rt = 1'b1; uses_imm = 1'b1; end
      OP_BEQ, OP_BNE: begin reads_rs = 1'b1; reads_rt = 1'b1; is_branch = 1'b1; end
      default:        ;
    endcase
  end

  // Register 0 is never written, so it never shows up as busy or saturated.
  assign wen      = has_dest && (dest != 5'd0);
  assign rs_busy  = reads_rs && (rs != 5'd0) && (sb_cnt[rs] != '0);
  assign rt_busy  = reads_rt && (rt != 5'd0) && (sb_cnt[rt] != '0);
  assign dest_sat = wen && (sb_cnt[dest] == {SB_CNT_W{1'b1}});
  assign hazard   = in_valid && (rs_busy || rt_busy || dest_sat);
  assign in_ready = br_taken ? 1'b1 : (!hazard && (!out_valid || out_ready) && !flush);
  assign accept   = in_valid && in_ready && !br_taken;
  assign br_cond  = (opcode == OP_BEQ) ? (rf_rdata1 == rf_rdata2) : (rf_rdata1 != rf_rdata2);

  // One-hot per-register increment and decrement requests for this cycle.
  assign inc_vec   = (accept && !is_branch && wen) ? (32'd1 << dest) : 32'd0;
  assign wbdec_vec = (wb_valid && (wb_rd != 5'd0)) ? (32'd1 << wb_rd) : 32'd0;
  assign fldec_vec = (flush && out_valid && out_wen) ? (32'd1 << out_dest) : 32'd0;

  // Net counter update: increments and decrements combine, floor at zero.
  always_comb begin
    sum = '0;
    dec = '0;
    for (int i = 0; i < 32; i++) begin
      sum        = CW'(sb_cnt[i]) + CW'(inc_vec[i]);
      dec        = CW'(wbdec_vec[i]) + CW'(fldec_vec[i]);
      sb_next[i] = (sum > dec) ? SB_CNT_W'(sum - dec) : '0;
    end
  end

  // Scoreboard counter registers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (!rst_n) sb_cnt[i] <= '0;
      else        sb_cnt[i] <= sb_next[i];
    end
  end

  // ID/EX output register and one-cycle branch redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_rs    <= '0;
      out_rt    <= '0;
      out_dest  <= '0;
      out_wen   <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_imm   <= '0;
      br_taken  <= 1'b0;
      br_target <= '0;
    end else begin
      br_taken <= 1'b0;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept && !is_branch) begin
        out_valid <= 1'b1;
        out_op    <= opcode;
        out_rs    <= rs;
        out_rt    <= rt;
        out_dest  <= dest;
        out_wen   <= wen;
        out_a     <= rf_rdata1;
        out_imm   <= imm_sext;
        out_b     <= uses_imm ? imm_sext : rf_rdata2;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && is_branch && br_cond) begin
        br_taken  <= 1'b1;
        br_target <= in_pc + br_off;
      end
    end
  end

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed bench for decode_scoreboard: hazards, saturation, branches,
// flush and reset, with hand-computed expectations.
module tb_decode_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, wb_valid, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, rf_rdata1, rf_rdata2;
  logic [4:0]  rf_raddr1, rf_raddr2, wb_rd, out_rs, out_rt, out_dest;
  logic [5:0]  out_op;
  logic        out_wen, br_taken, hazard;
  logic [31:0] out_a, out_b, out_imm, br_target;
  logic [31:0] rf_mem [32];

  int checks = 0;
  int errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];

  decode_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_rs(out_rs), .out_rt(out_rt), .out_dest(out_dest), .out_wen(out_wen),
    .out_a(out_a), .out_b(out_b), .out_imm(out_imm), .br_taken(br_taken),
    .br_target(br_target), .hazard(hazard)
  );

  // driver helpers
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr);
    in_valid = 1'b1;
    in_instr = instr;
    #1;
  endtask

  // scoreboard comparison point
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h100 + i;
    step();
    step();

    // reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_br_taken", br_taken, 0);
    chk("rst_br_target", br_target, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_cnt3", dut.sb_cnt[3], 0);
    rst_n = 1'b1;

    // add r0,r1,r2: write to r0 is dropped
    drive(enc_r(5'd1, 5'd2, 5'd0));
    chk("raddr1", rf_raddr1, 1);
    chk("raddr2", rf_raddr2, 2);
    chk("r0_in_ready", in_ready, 1);
    step();
    chk("r0_out_valid", out_valid, 1);
    chk("r0_out_wen", out_wen, 0);
    chk("r0_out_a", out_a, 32'h101);
    chk("r0_out_b", out_b, 32'h102);
    chk("r0_cnt0", dut.sb_cnt[0], 0);

    // RAW hazard: add r3,r1,r2 then add r4,r3,r3
    drive(enc_r(5'd1, 5'd2, 5'd3));
    chk("raw1_hazard", hazard, 0);
    step();
    chk("raw1_dest", out_dest, 3);
    chk("raw1_wen", out_wen, 1);
    chk("raw1_cnt3", dut.sb_cnt[3], 1);
    drive(enc_r(5'd3, 5'd3, 5'd4));
    chk("raw2_hazard", hazard, 1);
    chk("raw2_in_ready", in_ready, 0);
    step();
    chk("raw2_drained", out_valid, 0);
    chk("raw2_hazard_hold", hazard, 1);
    wb_valid = 1'b1; wb_rd = 5'd3; #1;
    chk("raw2_wb_cycle_ready", in_ready, 0);
    step();
    wb_valid = 1'b0; #1;
    chk("raw2_cnt3_clear", dut.sb_cnt[3], 0);
    chk("raw2_hazard_clear", hazard, 0);
    chk("raw2_ready", in_ready, 1);
    step();
    chk("raw2_out_valid", out_valid, 1);
    chk("raw2_out_rs", out_rs, 3);
    chk("raw2_out_dest", out_dest, 4);
    chk("raw2_cnt4", dut.sb_cnt[4], 1);
    in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd4;
    step();
    wb_valid = 1'b0;
    chk("raw2_cnt4_retired", dut.sb_cnt[4], 0);

    // saturation: three writes to r5 in flight, fourth stalls
    drive(enc_i(6'd8, 5'd0, 5'd5, 16'd1));
    step();
    step();
    step();
    chk("sat_cnt5_full", dut.sb_cnt[5], 3);
    chk("sat_hazard", hazard, 1);
    chk("sat_in_ready", in_ready, 0);
    step();
    chk("sat_cnt5_hold", dut.sb_cnt[5], 3);
    wb_valid = 1'b1; wb_rd = 5'd5;
    step();
    wb_valid = 1'b0; #1;
    chk("sat_cnt5_after_wb", dut.sb_cnt[5], 2);
    chk("sat_ready", in_ready, 1);
    step();
    chk("sat_accept_cnt5", dut.sb_cnt[5], 3);
    chk("sat_out_dest", out_dest, 5);
    chk("sat_out_b", out_b, 1);
    in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd5;
    step();
    step();
    step();
    wb_valid = 1'b0;
    chk("sat_cnt5_retired", dut.sb_cnt[5], 0);

    // beq taken with negative offset, then wrong-path instruction discarded
    rf_mem[1] = 32'd7; rf_mem[2] = 32'd7; in_pc = 32'h100;
    drive(enc_i(6'd4, 5'd1, 5'd2, 16'hFFFE));
    chk("beq_ready", in_ready, 1);
    step();
    chk("beq_taken", br_taken, 1);
    chk("beq_target", br_target, 32'hF8);
    chk("beq_no_out", out_valid, 0);
    drive(enc_i(6'd8, 5'd0, 5'd6, 16'd5));
    chk("beq_drain_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("beq_taken_one_cycle", br_taken, 0);
    chk("beq_discard_out", out_valid, 0);
    chk("beq_discard_cnt6", dut.sb_cnt[6], 0);

    // bne with equal operands: not taken, target holds
    in_pc = 32'h200;
    drive(enc_i(6'd5, 5'd1, 5'd2, 16'h0010));
    step();
    in_valid = 1'b0;
    chk("bne_nt_taken", br_taken, 0);
    chk("bne_nt_target", br_target, 32'hF8);
    chk("bne_nt_out", out_valid, 0);

    // bne with unequal operands: taken, positive offset
    rf_mem[2] = 32'd9;
    drive(enc_i(6'd5, 5'd1, 5'd2, 16'h0004));
    step();
    in_valid = 1'b0;
    chk("bne_t_taken", br_taken, 1);
    chk("bne_t_target", br_target, 32'h210);
    step();
    chk("bne_t_drop", br_taken, 0);

    // addi r2,r0,-1 held under backpressure, then flushed
    out_ready = 1'b0;
    drive(enc_i(6'd8, 5'd0, 5'd2, 16'hFFFF));
    step();
    in_valid = 1'b0;
    chk("bp_out_valid", out_valid, 1);
    chk("bp_out_imm", out_imm, 32'hFFFF_FFFF);
    chk("bp_out_b", out_b, 32'hFFFF_FFFF);
    chk("bp_cnt2", dut.sb_cnt[2], 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_imm", out_imm, 32'hFFFF_FFFF);
    end
    drive(enc_i(6'd8, 5'd0, 5'd9, 16'd1));
    chk("bp_blocked_ready", in_ready, 0);
    in_valid = 1'b0;
    flush = 1'b1; #1;
    chk("flush_ready", in_ready, 0);
    step();
    flush = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_cnt2", dut.sb_cnt[2], 0);
    out_ready = 1'b1;

    // coincident increment and retire on r7
    drive(enc_i(6'd8, 5'd0, 5'd7, 16'd3));
    step();
    chk("coin_cnt7_first", dut.sb_cnt[7], 1);
    wb_valid = 1'b1; wb_rd = 5'd7; #1;
    chk("coin_ready", in_ready, 1);
    step();
    chk("coin_cnt7_same", dut.sb_cnt[7], 1);
    chk("coin_out_valid", out_valid, 1);

    // reset overrides flush and writeback
    in_valid = 1'b0; rst_n = 1'b0; flush = 1'b1;
    step();
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_cnt7", dut.sb_cnt[7], 0);
    chk("rst2_out_imm", out_imm, 0);
    chk("rst2_br_target", br_target, 0);
    rst_n = 1'b1; flush = 1'b0; wb_valid = 1'b0;
    drive(enc_r(5'd1, 5'd2, 5'd3));
    chk("post_rst_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("post_rst_out_valid", out_valid, 1);
    chk("post_rst_out_a", out_a, 32'd7);
    chk("post_rst_out_b", out_b, 32'd9);
    chk("post_rst_cnt3", dut.sb_cnt[3], 1);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_scoreboard.md
DECODE_SCOREBOARD -- requirements
Module: decode_scoreboard

Interface
REQ-001 Parameter XLEN, default 32, datapath width of operands and immediates.
REQ-002 Parameter PC_W, default 32, program-counter width.
REQ-003 Parameter SB_CNT_W, default 2, width of each per-register outstanding-write counter.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1 / in_ready  out  1  handshake from the IF/ID register.
REQ-007 in_instr  in  32  MIPS instruction; in_pc  in  PC_W  PC+4 of that instruction.
REQ-008 rf_raddr1, rf_raddr2  out  5  register-file read indices; rf_rdata1, rf_rdata2  in  XLEN  same-cycle read data.
REQ-009 wb_valid  in  1, wb_rd  in  5  write-retire notification from writeback.
REQ-010 flush  in  1  kill request from a later stage.
REQ-011 out_valid  out  1 / out_ready  in  1  handshake to the ID/EX stage.
REQ-012 out_op  out  6; out_rs, out_rt, out_dest  out  5; out_wen  out  1; out_a, out_b, out_imm  out  XLEN.
REQ-013 br_taken  out  1, br_target  out  PC_W  registered branch redirect.
REQ-014 hazard  out  1  combinational RAW/saturation stall indicator.

Function
REQ-015 rf_raddr1 = in_instr[25:21], rf_raddr2 = in_instr[20:16], combinational.
REQ-016 Decode classes by opcode: 0 R-type (reads rs,rt; dest rd); 8 addi (reads rs; dest rt); 35 lw (reads rs; dest rt); 43 sw (reads rs,rt; no dest); 4 beq, 5 bne (read rs,rt; no dest); any other: no reads, no dest.
REQ-017 A dest of register 0 yields out_wen=0; register 0 is never tracked and never causes a hazard.
REQ-018 Scoreboard holds 32 counters of SB_CNT_W bits; register r is busy when its counter is nonzero.
REQ-019 hazard = in_valid AND (any read source busy OR dest counter equals 2^SB_CNT_W-1).
REQ-020 in_ready = !br_taken ? (!hazard AND (!out_valid OR out_ready) AND !flush) : 1.
REQ-021 Accept = in_valid AND in_ready AND !br_taken; latency from accept to out_valid is 1 cycle.
REQ-022 On accept of a non-branch: out_valid<=1, out_op<=opcode, out_rs/out_rt/out_dest/out_wen loaded, out_a<=rf_rdata1, out_imm<=sign-extension of in_instr[15:0] to XLEN, out_b<=out_imm for addi/lw/sw else rf_rdata2.
REQ-023 On accept with out_wen=1, the dest counter increments by 1.
REQ-024 out_valid AND out_ready with no new accept clears out_valid; output data holds when not consumed.
REQ-025 On accept of beq (equal) or bne (not equal) with condition true: br_taken<=1 for exactly one cycle, br_target<=in_pc + (sext(imm) << 2) truncated to PC_W; branches never set out_valid.
REQ-026 While br_taken=1, an in_valid instruction is consumed and discarded: no output, no scoreboard change.
REQ-027 wb_valid with wb_rd nonzero decrements that counter, saturating at 0.
REQ-028 Increment and decrement on the same register in one cycle leave the counter unchanged.
REQ-029 flush: out_valid<=0, br_taken<=0, no accept; if out_valid AND out_wen, counter of out_dest decrements (saturating at 0), combined additively with any same-cycle wb decrement.
REQ-030 Downstream stages report wb_valid for every instruction killed after leaving this block.

Reset
REQ-031 rst_n low at a rising edge: out_valid=0, br_taken=0, br_target=0, all out_* data=0, all 32 counters=0; rst_n overrides flush and wb_valid.
REQ-032 Reset asserted mid-stall or mid-branch discards all in-flight state; first accept possible the cycle after rst_n rises.

Verification
REQ-033 add r3,r1,r2 accepted, then add r4,r3,r3 presented -> hazard=1, in_ready=0 until wb_valid wb_rd=3; accepted the cycle after, out_rs=3.
REQ-034 SB_CNT_W=2, three writes to r5 issued without retirement, fourth presented -> stall; one wb_valid r5 -> fourth accepted next cycle.
REQ-035 beq with rf_rdata1=rf_rdata2=7, in_pc=0x100, imm=0xFFFE -> br_taken=1 one cycle, br_target=0xF8, next in_valid instruction discarded.
REQ-036 addi r2,r0,-1 with out_ready=0 for 3 cycles -> out_valid=1, out_imm=out_b=0xFFFFFFFF held stable; then flush -> out_valid=0, r2 counter back to 0.
REQ-037 wb_valid r7 coincident with accept writing r7 (counter 1) -> counter stays 1; rst_n=0 afterward -> all counters 0, out_valid=0.
